pe_fc_layer_gen: RTL

Parametrised fully-connected synapse processing element for the spiking FC layers. It buffers one frame of presynaptic spike indices and replays them once per output channel. For each (channel, spike) pair it fetches the signed weight from an internal run-time-loadable weight RAM. Weights stream to the MP refresh stage over a valid/ready interface with per-channel and per-frame markers. It replaces the fixed-table, fixed-size FC PE and the external per-channel index replay.

---
 rtl/pe_fc_layer_gen_pkg.sv | 16 +
 rtl/pe_fc_layer_gen_fc_weight_ram.sv | 23 ++
 rtl/pe_fc_layer_gen.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pe_fc_layer_gen_pkg.sv
// Shared definitions for the fully-connected synapse processing element.
package pe_fc_layer_gen_pkg;

    localparam int FC_IN_CH   = 128;
    localparam int FC_OUT_CH  = 256;
    localparam int FC_W_WIDTH = 8;
    localparam int FC_IDX_W   = $clog2(FC_IN_CH);
    localparam int FC_CH_W    = $clog2(FC_OUT_CH);

    typedef enum logic [1:0] {
        FC_IDLE    = 2'd0,
        FC_COLLECT = 2'd1,
        FC_REPLAY  = 2'd2
    } fc_state_t;

endpackage

// File: rtl/pe_fc_layer_gen_fc_weight_ram.sv
// Weight store: one write port, one registered read port with enable, read-first.
module fc_weight_ram #(
    parameter int DEPTH   = 32768,
    parameter int ADDR_W  = 15,
    parameter int W_WIDTH = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [W_WIDTH-1:0] wr_data,
    input  logic               re,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [W_WIDTH-1:0] rd_data
);

    logic [W_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        if (re) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pe_fc_layer_gen.sv
// FC synapse PE: buffers one frame of spike indices, replays them per output
// channel and streams the addressed weights through a 3-stage stallable pipeline.
module pe_fc_layer_gen
    import pe_fc_layer_gen_pkg::*;
#(
    parameter int IN_CH      = FC_IN_CH,
    parameter int OUT_CH     = FC_OUT_CH,
    parameter int W_WIDTH    = FC_W_WIDTH,
    parameter int MAX_SPIKES = 128,
    parameter int IDX_W      = $clog2(IN_CH),
    parameter int CH_W       = $clog2(OUT_CH),
    parameter int ADDR_W     = $clog2(IN_CH * OUT_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   s_index,
    input  logic               s_valid,
    input  logic               s_last,
    input  logic               s_empty,
    output logic               s_ready,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [W_WIDTH-1:0] wr_data,
    output logic               wr_err,
    output logic [W_WIDTH-1:0] m_weight,
    output logic [CH_W-1:0]    m_channel,
    output logic               m_ch_last,
    output logic               m_frame_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               frame_done,
    output logic               overflow
);

    localparam int CNT_W = $clog2(MAX_SPIKES + 1);
    localparam int PTR_W = (MAX_SPIKES > 1) ? $clog2(MAX_SPIKES) : 1;

    fc_state_t          state;
    logic [CNT_W-1:0]   count;
    logic [IDX_W-1:0]   spike_mem [MAX_SPIKES];

    logic [CH_W-1:0]    c_iss;
    logic [CNT_W-1:0]   p_iss;
    logic               issue_done;

    logic               advance;
    logic               issue;
    logic               issue_ch_last;
    logic               issue_last_ch;
    logic               accept;
    logic               store;

    logic               a_valid, a_ch_last, a_frame_last, a_zero;
    logic [CH_W-1:0]    a_ch;
    logic [IDX_W-1:0]   a_idx;

    logic               b_valid, b_ch_last, b_frame_last, b_zero;
    logic [CH_W-1:0]    b_ch;

    logic               ram_we;
    logic [W_WIDTH-1:0] ram_q;

    // Every stage moves together; a stalled output freezes the whole pipe,
    // including the RAM read register, so no skid buffer is needed.
    assign advance       = !m_valid || m_ready;
    assign issue         = (state == FC_REPLAY) && !issue_done && advance;
    assign issue_ch_last = (count == '0) || (p_iss == count - CNT_W'(1));
    assign issue_last_ch = (c_iss == CH_W'(OUT_CH - 1));
    assign accept        = s_valid && s_ready;
    assign store         = accept && !s_empty && (count < CNT_W'(MAX_SPIKES));
    assign ram_we        = wr_en && (state != FC_REPLAY) && !rst;

    always_ff @(posedge clk) begin
        if (store) spike_mem[count[PTR_W-1:0]] <= s_index;
        if (issue) a_idx <= spike_mem[p_iss[PTR_W-1:0]];
    end

    fc_weight_ram #(
        .DEPTH   (IN_CH * OUT_CH),
        .ADDR_W  (ADDR_W),
        .W_WIDTH (W_WIDTH)
    ) u_weight_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .re      (advance),
        .rd_addr ({a_ch, a_idx}),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FC_IDLE;
            count        <= '0;
            overflow     <= 1'b0;
            s_ready      <= 1'b1;
            frame_done   <= 1'b0;
            wr_err       <= 1'b0;
            c_iss        <= '0;
            p_iss        <= '0;
            issue_done   <= 1'b0;
            a_valid      <= 1'b0;
            a_ch         <= '0;
            a_ch_last    <= 1'b0;
            a_frame_last <= 1'b0;
            a_zero       <= 1'b0;
            b_valid      <= 1'b0;
            b_ch         <= '0;
            b_ch_last    <= 1'b0;
            b_frame_last <= 1'b0;
            b_zero       <= 1'b0;
            m_valid      <= 1'b0;
            m_weight     <= '0;
            m_channel    <= '0;
            m_ch_last    <= 1'b0;
            m_frame_last <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            wr_err     <= wr_en && (state == FC_REPLAY);
            if (accept && !s_empty && !store) overflow <= 1'b1;
            if (store) count <= count + CNT_W'(1);

            case (state)
                FC_IDLE, FC_COLLECT: begin
                    if (accept) begin
                        if (s_last) begin
                            state      <= FC_REPLAY;
                            s_ready    <= 1'b0;
                            c_iss      <= '0;
                            p_iss      <= '0;
                            issue_done <= 1'b0;
                        end else if (!s_empty) begin
                            state <= FC_COLLECT;
                        end
                    end
                end
                FC_REPLAY: begin
                    if (issue) begin
                        if (issue_ch_last) begin
                            p_iss <= '0;
                            if (issue_last_ch) issue_done <= 1'b1;
                            else               c_iss <= c_iss + CH_W'(1);
                        end else begin
                            p_iss <= p_iss + CNT_W'(1);
                        end
                    end
                    if (m_valid && m_ready && m_frame_last) begin
                        state      <= FC_IDLE;
                        s_ready    <= 1'b1;
                        frame_done <= 1'b1;
                        count      <= '0;
                    end
                end
                default: begin
                    state   <= FC_IDLE;
                    s_ready <= 1'b1;
                end
            endcase

            if (advance) begin
                a_valid      <= issue;
                a_ch         <= c_iss;
                a_ch_last    <= issue_ch_last;
                a_frame_last <= issue_ch_last && issue_last_ch;
                a_zero       <= (count == '0);

                b_valid      <= a_valid;
                b_ch         <= a_ch;
                b_ch_last    <= a_ch_last;
                b_frame_last <= a_frame_last;
                b_zero       <= a_zero;

                // An empty frame still visits every channel, carrying zero weight.
                m_valid      <= b_valid;
                m_weight     <= b_zero ? '0 : ram_q;
                m_channel    <= b_ch;
                m_ch_last    <= b_valid && b_ch_last;
                m_frame_last <= b_valid && b_frame_last;
            end
        end
    end

endmodule
